dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Target-side data-memory responder for the CPU data port.
- Accepts CPU load/store requests (address, write data, write strobe, dm_ctrl access type) and performs the access on an internal word-organised RAM.
- Applies sub-word write masking and load sign/zero extension, with a configurable wait-state count.
- Completes each access with a one-cycle ready pulse, which drives the CPU's MIO_ready input.

Parameters:
- ADDR_W, 10, word-index width; RAM depth is 2^ADDR_W 32-bit words.
- WAIT_STATES, 1, extra stall cycles inserted before the access cycle (0..15).

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  access request; held high by the CPU until ready.
- mem_w  input  1  1 = store, 0 = load; sampled with req.
- addr  input  32  byte address (CPU ALU result).
- wdata  input  32  store data (CPU rs2 value).
- dm_ctrl  input  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101..111 are illegal.
- rdata  output  32  extended load data; valid only while ready = 1.
- ready  output  1  one-cycle completion pulse.
- err  output  1  misaligned or illegal access; valid with ready.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; ready = 0, rdata = 0, err = 0; wait counter is cleared.
  - RAM contents are not reset.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - On a rising edge with req = 1, latch mem_w, addr, wdata and dm_ctrl.
  - Go to WAIT with counter = WAIT_STATES, or to ACCESS if WAIT_STATES = 0.
  - Input changes after the latch edge are ignored.
- WAIT: counter decrements each cycle; go to ACCESS when it reaches 0.
- ACCESS (exactly one cycle):
  - The RAM read or write occurs on the exiting edge.
  - The registered rdata and err are loaded, then the state goes to DONE.
- DONE: ready = 1 for exactly one cycle, then IDLE. req is ignored in DONE.
- Back-to-back requests: a new request is accepted at the earliest on the first IDLE edge after DONE.
- Latency: ready is high in the cycle starting WAIT_STATES + 2 edges after the accept edge.
- Requests cannot be cancelled. Dropping req after acceptance still completes the access, including the ready pulse.
- Word index: addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Alignment rules:
  - Word access requires addr[1:0] = 00.
  - Half access requires addr[0] = 0.
  - Byte access is always aligned.
- Misaligned access or illegal dm_ctrl:
  - No RAM write; rdata = 0, err = 1.
  - Normal timing still applies, and ready still pulses.
- Stores (read-modify-write within the ACCESS cycle, unaffected bytes preserved):
  - Word: all 4 bytes written.
  - Half: wdata[15:0] written to byte lanes addr[1]*2 and addr[1]*2+1.
  - Byte: wdata[7:0] written to lane addr[1:0].
- Loads:
  - The selected lane(s) are right-justified in rdata.
  - Signed types replicate the top bit of the selected field into the upper bits; unsigned types zero-fill.
  - rdata on a store completion is 0.
- Outside the ready cycle, rdata and err hold 0.
- Reset during WAIT or ACCESS (before the exiting ACCESS edge) aborts the access: no RAM write and no ready pulse.

Test Plan:
1. WAIT_STATES = 1. Word store 0xDEADBEEF at addr 0x10, then word load at 0x10 → ready pulses exactly 3 edges after each accept; load rdata = 0xDEADBEEF, err = 0.
2. Byte store 0x7F at 0x11 and half store 0x8001 at 0x12 over prior 0xDEADBEEF, then:
   - word load at 0x10 → 0x80017FEF;
   - LB at 0x13 → 0xFFFFFF80;
   - LBU at 0x13 → 0x00000080;
   - LH at 0x12 → 0xFFFF8001.
3. Misalignment and illegal type:
   - Word load at 0x13 → err = 1, rdata = 0.
   - Half store at 0x21 → err = 1, and a following word load at 0x20 returns the prior value unchanged.
   - dm_ctrl = 111 → err = 1.
4. req dropped one cycle after accept, and addr/wdata changed after accept → access completes with the latched values; ready pulses once.
5. Assert reset during WAIT of a store to 0x40 → ready stays 0, outputs go to 0 immediately, and a later load at 0x40 returns the pre-store value.
6. ADDR_W = 10. Word store at 0x1000 → a load at 0x0 returns the stored value (wrap).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU data port: one load/store per request, sub-word
// masking and load extension, WAIT_STATES stall cycles, one-cycle ready pulse.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic                mem_w_reg;
    logic [ADDR_W+1:0]   addr_reg;
    logic [31:0]         wdata_reg;
    logic [2:0]          ctrl_reg;

    logic [31:0]         ram [0:(1<<ADDR_W)-1];
    logic [31:0]         ram_q;

    logic                is_word, is_half, is_byte, is_signed, access_err;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         byte_shift;
    logic [31:0]         load_data;
    logic [3:0]          byte_en;
    logic [31:0]         wlane;
    logic [31:0]         merged;
    logic                ram_re, ram_we;

    // Upper address bits are deliberately dropped so accesses wrap modulo the RAM size.
    logic unused_addr;
    assign unused_addr = &{1'b0, addr[31:ADDR_W+2]};

    always_comb begin
        is_word    = (ctrl_reg == 3'b000);
        is_half    = (ctrl_reg == 3'b001) || (ctrl_reg == 3'b010);
        is_byte    = (ctrl_reg == 3'b011) || (ctrl_reg == 3'b100);
        is_signed  = (ctrl_reg == 3'b001) || (ctrl_reg == 3'b011);
        access_err = !(is_word || is_half || is_byte)
                   || (is_word && (addr_reg[1:0] != 2'b00))
                   || (is_half && addr_reg[0]);
    end

    always_comb begin
        byte_shift = ram_q >> {addr_reg[1:0], 3'b000};
        byte_sel   = byte_shift[7:0];
        half_sel   = addr_reg[1] ? ram_q[31:16] : ram_q[15:0];
        load_data  = 32'h0;
        if (!mem_w_reg && !access_err) begin
            if (is_word)
                load_data = ram_q;
            else if (is_half)
                load_data = {{16{is_signed & half_sel[15]}}, half_sel};
            else
                load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        wlane   = wdata_reg;
        if (is_word) begin
            byte_en = 4'b1111;
        end else if (is_half) begin
            byte_en = addr_reg[1] ? 4'b1100 : 4'b0011;
            wlane   = {2{wdata_reg[15:0]}};
        end else if (is_byte) begin
            byte_en = 4'b0001 << addr_reg[1:0];
            wlane   = {4{wdata_reg[7:0]}};
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = byte_en[gi] ? wlane[gi*8 +: 8] : ram_q[gi*8 +: 8];
        end
    endgenerate

    // The word is fetched on the accept edge so ACCESS sees it in ram_q; reset gates the
    // write so an access aborted at the exiting edge leaves memory untouched.
    assign ram_re = (state_reg == IDLE) && req;
    assign ram_we = (state_reg == ACCESS) && mem_w_reg && !access_err && reset;

    always_ff @(posedge clk) begin
        if (ram_re)
            ram_q <= ram[addr[ADDR_W+1:2]];
        if (ram_we)
            ram[addr_reg[ADDR_W+1:2]] <= merged;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            mem_w_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 32'h0;
            ctrl_reg  <= 3'b000;
            rdata     <= 32'h0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready <= 1'b0;
                    rdata <= 32'h0;
                    err   <= 1'b0;
                    if (req) begin
                        mem_w_reg <= mem_w;
                        addr_reg  <= addr[ADDR_W+1:0];
                        wdata_reg <= wdata;
                        ctrl_reg  <= dm_ctrl;
                        if (WAIT_STATES == 0) begin
                            state_reg <= ACCESS;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= 4'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0)
                        state_reg <= ACCESS;
                    else
                        cnt_reg <= cnt_reg - 4'd1;
                end
                ACCESS: begin
                    rdata     <= load_data;
                    err       <= access_err;
                    ready     <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    rdata     <= 32'h0;
                    err       <= 1'b0;
                    ready     <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one task per scenario, each with inline checks.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_ctrl;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.ADDR_W(10), .WAIT_STATES(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .mem_w   (mem_w),
        .addr    (addr),
        .wdata   (wdata),
        .dm_ctrl (dm_ctrl),
        .rdata   (rdata),
        .ready   (ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Drives one request, holds req until ready, and reports data, err, latency in edges
    // after the accept edge, and ready one edge after the pulse.
    task automatic do_access(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] ctrl, output logic [31:0] rd,
                             output logic er, output int lat, output logic rdy_after);
        logic got;
        @(negedge clk);
        req = 1'b1; mem_w = mw; addr = a; wdata = wd; dm_ctrl = ctrl;
        @(posedge clk);
        got = 1'b0; lat = 0; rd = 32'h0; er = 1'b0;
        while (!got && lat < 16) begin
            @(posedge clk);
            lat++;
            #1;
            if (ready === 1'b1) begin
                got = 1'b1; rd = rdata; er = err;
            end
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        rdy_after = ready;
        $display("txn mw=%0b addr=%h wdata=%h ctrl=%0d -> rdata=%h err=%0b latency=%0d",
                 mw, a, wd, ctrl, rd, er, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; mem_w = 1'b0; addr = '0; wdata = '0; dm_ctrl = '0;
        #2 reset = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; logic ra;
        do_access(1'b1, 32'h10, 32'hDEADBEEF, 3'b000, rd, er, lat, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d expected 3", lat); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_result: got rdata=%h err=%b expected 00000000 0", rd, er); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL sw_pulse_width: ready after pulse %b expected 0", ra); end
        do_access(1'b0, 32'h10, 32'h0, 3'b000, rd, er, lat, ra);
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", er); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er; int lat; logic ra;
        do_access(1'b1, 32'h11, 32'hAAAAAA7F, 3'b011, rd, er, lat, ra);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sb_err: got %b expected 0", er); end
        do_access(1'b1, 32'h12, 32'h55558001, 3'b001, rd, er, lat, ra);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sh_err: got %b expected 0", er); end
        do_access(1'b0, 32'h10, 32'h0, 3'b000, rd, er, lat, ra);
        checks++; if (rd !== 32'h80017FEF) begin errors++; $display("FAIL merged_word: got %h expected 80017fef", rd); end
        do_access(1'b0, 32'h13, 32'h0, 3'b011, rd, er, lat, ra);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_neg: got %h expected ffffff80", rd); end
        do_access(1'b0, 32'h13, 32'h0, 3'b100, rd, er, lat, ra);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h expected 00000080", rd); end
        do_access(1'b0, 32'h12, 32'h0, 3'b001, rd, er, lat, ra);
        checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_neg: got %h expected ffff8001", rd); end
        do_access(1'b0, 32'h11, 32'h0, 3'b011, rd, er, lat, ra);
        checks++; if (rd !== 32'h0000007F) begin errors++; $display("FAIL lb_pos: got %h expected 0000007f", rd); end
        do_access(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat, ra);
        checks++; if (rd !== 32'h00007FEF) begin errors++; $display("FAIL lhu_low: got %h expected 00007fef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; logic ra;
        do_access(1'b0, 32'h13, 32'h0, 3'b000, rd, er, lat, ra);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misaligned: got err=%b rdata=%h expected 1 00000000", er, rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL err_latency: got %0d expected 3", lat); end
        do_access(1'b1, 32'h20, 32'hA5A5A5A5, 3'b000, rd, er, lat, ra);
        do_access(1'b1, 32'h21, 32'h0000FFFF, 3'b001, rd, er, lat, ra);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL sh_misaligned: got err=%b expected 1", er); end
        do_access(1'b0, 32'h20, 32'h0, 3'b000, rd, er, lat, ra);
        checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin errors++; $display("FAIL no_write_on_err: got %h err=%b expected a5a5a5a5 0", rd, er); end
        do_access(1'b0, 32'h10, 32'h0, 3'b111, rd, er, lat, ra);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL illegal_111: got err=%b rdata=%h expected 1 00000000", er, rd); end
        do_access(1'b0, 32'h10, 32'h0, 3'b101, rd, er, lat, ra);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL illegal_101: got err=%b rdata=%h expected 1 00000000", er, rd); end
    endtask

    task automatic test_req_drop();
        logic [31:0] rd; logic er; int lat; logic ra; int pulses;
        @(negedge clk);
        req = 1'b1; mem_w = 1'b1; addr = 32'h30; wdata = 32'h12345678; dm_ctrl = 3'b000;
        @(posedge clk);
        #1;
        addr = 32'h34; wdata = 32'hFFFFFFFF; dm_ctrl = 3'b011; mem_w = 1'b0;
        @(posedge clk);
        #1 req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) pulses++;
        end
        $display("txn dropped-req store addr=00000030 wdata=12345678 -> ready pulses=%0d", pulses);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL drop_pulses: got %0d expected 1", pulses); end
        do_access(1'b0, 32'h30, 32'h0, 3'b000, rd, er, lat, ra);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL drop_latched: got %h expected 12345678", rd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; logic ra; int pulses;
        do_access(1'b1, 32'h40, 32'hCAFEF00D, 3'b000, rd, er, lat, ra);
        // Reset landing in the ready cycle of a load must clear outputs at once.
        @(negedge clk);
        req = 1'b1; mem_w = 1'b0; addr = 32'h10; dm_ctrl = 3'b000;
        @(posedge clk);
        lat = 0;
        while (ready !== 1'b1 && lat < 16) begin
            @(posedge clk);
            lat++;
            #1;
        end
        req = 1'b0;
        reset = 1'b0;
        #1;
        $display("txn load addr=00000010 reset in ready cycle -> ready=%b rdata=%h", ready, rdata);
        checks++; if (ready !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL async_clear: got ready=%b rdata=%h expected 0 00000000", ready, rdata); end
        @(negedge clk) reset = 1'b1;
        // Store aborted by reset during WAIT.
        @(negedge clk);
        req = 1'b1; mem_w = 1'b1; addr = 32'h40; wdata = 32'h11111111; dm_ctrl = 3'b000;
        @(posedge clk);
        #1;
        req = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) pulses++;
        end
        $display("txn store addr=00000040 aborted by reset -> ready pulses=%0d", pulses);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pulse: got %0d expected 0", pulses); end
        do_access(1'b0, 32'h40, 32'h0, 3'b000, rd, er, lat, ra);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_no_write: got %h expected cafef00d", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL abort_recover_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat; logic ra;
        do_access(1'b1, 32'h1000, 32'h0BADC0DE, 3'b000, rd, er, lat, ra);
        do_access(1'b0, 32'h0, 32'h0, 3'b000, rd, er, lat, ra);
        checks++; if (rd !== 32'h0BADC0DE) begin errors++; $display("FAIL wrap_load: got %h expected 0badc0de", rd); end
        do_access(1'b0, 32'h10, 32'h0, 3'b000, rd, er, lat, ra);
        checks++; if (rd !== 32'h80017FEF) begin errors++; $display("FAIL wrap_neighbour: got %h expected 80017fef", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_req_drop();
        test_reset_abort();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
